pmp_csr_file: RTL

// - CSR-side writer/reader for the PMP checker; owns the pmpcfg/pmpaddr state that the checker consumes.
// - Accepts CSR read/write requests from the core's CSR unit over a req/ready + rvalid handshake.
// - Applies WARL legalisation and lock rules (L bit, TOR back-lock) before committing writes.
// - Drives io_pmpcfg/io_pmpaddr straight from registers; no combinational path from CSR inputs.

---
 rtl/pmp_csr_file.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pmp_csr_file.sv
// pmp_csr_file: CSR-side owner of the pmpcfg/pmpaddr state used by the PMP checker.
// Each access runs IDLE -> EXEC -> RESP. The write commits at the end of EXEC, after
// the WARL and lock filters have been applied.
// Optional feature: define PMP_WR_ERR_EN to flag lock-filtered writes with err=1.
//
// state | meaning
// IDLE  | ready=1, waiting for io_csr_req; latches we/addr/wdata on accept
// EXEC  | decode, lock check, commit write, register response
// RESP  | rvalid=1 for exactly this cycle
module pmp_csr_file #(
    parameter int          VLEN    = 31,
    parameter int          PMP_CNT = 16,
    parameter logic [1:0]  A1_TOR  = 2'b01
) (
    input  logic                          io_clk,
    input  logic                          io_rst_n,
    input  logic                          io_csr_req,
    input  logic                          io_csr_we,
    input  logic [11:0]                   io_csr_addr,
    input  logic [31:0]                   io_csr_wdata,
    output logic                          io_csr_ready,
    output logic                          io_csr_rvalid,
    output logic [31:0]                   io_csr_rdata,
    output logic                          io_csr_err,
    output logic [PMP_CNT-1:0][7:0]       io_pmpcfg,
    output logic [PMP_CNT-1:0][VLEN:0]    io_pmpaddr
);

    localparam int IW = $clog2(PMP_CNT);

`ifdef PMP_WR_ERR_EN
    localparam logic WR_ERR = 1'b1;
`else
    localparam logic WR_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t                      state;
    logic                        lat_we;
    logic [11:0]                 lat_addr;
    logic [31:0]                 lat_wdata;

    logic [PMP_CNT-1:0][7:0]     next_cfg;
    logic [PMP_CNT-1:0][VLEN:0]  next_addr;
    logic [31:0]                 resp_rdata;
    logic                        resp_err;
    logic                        lock_hit;
    logic                        addr_lock;
    logic                        is_cfg;
    logic                        is_addr;
    logic [IW-1:0]               ci;
    logic [IW-1:0]               ai;
    logic [IW-1:0]               an;
    int                          idx;

    // WARL: reserved bits read as zero, W=1 without R is not a legal combination
    function automatic logic [7:0] legal_cfg(input logic [7:0] b);
        logic [7:0] v;
        v = b & 8'h9F;
        if (v[1:0] == 2'b10) v[1:0] = 2'b00;
        return v;
    endfunction

    assign idx     = int'({28'd0, lat_addr[3:0]});
    assign is_cfg  = (lat_addr[11:4] == 8'h3A) && (idx < PMP_CNT / 4);
    assign is_addr = (lat_addr[11:4] == 8'h3B) && (idx < PMP_CNT);

    // Decode the latched request against pre-write register values and form the commit/response
    always_comb begin
        next_cfg   = io_pmpcfg;
        next_addr  = io_pmpaddr;
        resp_rdata = '0;
        resp_err   = 1'b0;
        lock_hit   = 1'b0;
        addr_lock  = 1'b0;
        ci         = '0;
        ai         = '0;
        an         = '0;
        if (is_cfg) begin
            for (int j = 0; j < 4; j++) begin
                ci = IW'(idx * 4 + j);
                if (lat_we) begin
                    if (io_pmpcfg[ci][7]) lock_hit = 1'b1;
                    else                  next_cfg[ci] = legal_cfg(lat_wdata[8*j +: 8]);
                end
                resp_rdata[8*j +: 8] = next_cfg[ci];
            end
        end else if (is_addr) begin
            ai        = IW'(idx);
            addr_lock = io_pmpcfg[ai][7];
            // the next entry in TOR mode uses this address as its base, so its lock covers it too
            if (idx < PMP_CNT - 1) begin
                an = IW'(idx + 1);
                if (io_pmpcfg[an][7] && (io_pmpcfg[an][4:3] == A1_TOR)) addr_lock = 1'b1;
            end
            if (lat_we) begin
                if (addr_lock) lock_hit = 1'b1;
                else           next_addr[ai] = lat_wdata[VLEN:0];
            end
            resp_rdata = 32'(next_addr[ai]);
        end else begin
            resp_err = 1'b1;
        end
        resp_err = resp_err | (WR_ERR & lock_hit);
    end

    // Access sequencer with registered handshake outputs and state commit
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state         <= ST_IDLE;
            lat_we        <= 1'b0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            io_csr_ready  <= 1'b1;
            io_csr_rvalid <= 1'b0;
            io_csr_rdata  <= '0;
            io_csr_err    <= 1'b0;
            io_pmpcfg     <= '0;
            io_pmpaddr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    io_csr_rvalid <= 1'b0;
                    if (io_csr_req) begin
                        lat_we       <= io_csr_we;
                        lat_addr     <= io_csr_addr;
                        lat_wdata    <= io_csr_wdata;
                        io_csr_ready <= 1'b0;
                        state        <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    io_pmpcfg     <= next_cfg;
                    io_pmpaddr    <= next_addr;
                    io_csr_rdata  <= resp_rdata;
                    io_csr_err    <= resp_err;
                    io_csr_rvalid <= 1'b1;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    io_csr_rvalid <= 1'b0;
                    io_csr_ready  <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: begin
                    io_csr_rvalid <= 1'b0;
                    io_csr_ready  <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
